// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM states
// and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    WR2  = 2'd3
  } lsu_state_e;

  // Byte mask for an access of the size encoded in funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   return off == 2'd3;
      2'b10:   return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return f3 > F3_W;
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_align_lane.sv
// Combinational byte-lane steering: shifted write data / byte enables for both
// halves of an access, and extraction plus sign/zero extension of read data.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] rdata
);

  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] raw;

  // Shifting into a double-width vector yields both halves of a word-crossing access.
  assign be_wide  = {4'b0000, size_mask(funct3[1:0])} << off;
  assign wd_wide  = {32'h0, wdata} << {off, 3'b000};
  assign be_lo    = be_wide[3:0];
  assign be_hi    = be_wide[7:4];
  assign wdata_lo = wd_wide[31:0];
  assign wdata_hi = wd_wide[63:32];

  assign raw = 32'({rd_hi, rd_lo} >> {off, 3'b000});

  always_comb begin
    case (funct3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   rdata = {24'h0, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   rdata = {16'h0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a byte-enabled RAM with 1-cycle read latency.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two RAM cycles.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_q
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  localparam logic [AW-1:0] WMASK = AW'(DEPTH_WORDS - 1);

  lsu_state_e    state_reg;
  logic [AW-1:0] word_reg;
  logic [1:0]    off_reg;
  logic [2:0]    f3_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   lo_reg;
  logic          split_reg;

  logic [AW-1:0] req_word, word_nxt;
  logic          req_err, req_split;
  logic          idle;
  logic [1:0]    lane_off;
  logic [2:0]    lane_f3;
  logic [31:0]   lane_wdata, lane_rd_lo, lane_rd_hi;
  logic [31:0]   lane_wdata_lo, lane_wdata_hi, lane_rdata;
  logic [3:0]    lane_be_lo, lane_be_hi;

  assign idle      = (state_reg == IDLE);
  assign req_ready = idle;
  assign req_word  = (req_addr >> 2) & WMASK;
  assign word_nxt  = (word_reg + AW'(1)) & WMASK;
  assign req_err   = is_illegal(req_we, req_funct3) ||
                     (is_misaligned(req_funct3[1:0], req_addr[1:0]) && !SPLIT_EN);
  assign req_split = is_misaligned(req_funct3[1:0], req_addr[1:0]) && SPLIT_EN;

  // In IDLE the lane works on the live request, otherwise on the registered one.
  assign lane_off   = idle ? req_addr[1:0] : off_reg;
  assign lane_f3    = idle ? req_funct3 : f3_reg;
  assign lane_wdata = idle ? req_wdata : wdata_reg;
  assign lane_rd_lo = (state_reg == RD2) ? lo_reg : ram_q;
  assign lane_rd_hi = (state_reg == RD2) ? ram_q : 32'h0;

  lsu_lane u_lane (
    .off      (lane_off),
    .funct3   (lane_f3),
    .wdata    (lane_wdata),
    .rd_lo    (lane_rd_lo),
    .rd_hi    (lane_rd_hi),
    .wdata_lo (lane_wdata_lo),
    .wdata_hi (lane_wdata_hi),
    .be_lo    (lane_be_lo),
    .be_hi    (lane_be_hi),
    .rdata    (lane_rdata)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_be    = lane_be_lo;
    ram_wdata = lane_wdata_lo;
    ram_waddr = word_reg;
    ram_raddr = word_reg;
    case (state_reg)
      IDLE: begin
        ram_we    = !rst && req_valid && req_we && !req_err;
        ram_waddr = req_word;
        ram_raddr = req_word;
      end
      RD1:  ram_raddr = split_reg ? word_nxt : word_reg;
      RD2:  ram_raddr = word_nxt;
      WR2: begin
        ram_we    = !rst;
        ram_be    = lane_be_hi;
        ram_wdata = lane_wdata_hi;
        ram_waddr = word_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      word_reg  <= '0;
      off_reg   <= 2'd0;
      f3_reg    <= 3'd0;
      wdata_reg <= 32'h0;
      lo_reg    <= 32'h0;
      split_reg <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: if (req_valid) begin
          word_reg  <= req_word;
          off_reg   <= req_addr[1:0];
          f3_reg    <= req_funct3;
          wdata_reg <= req_wdata;
          split_reg <= req_split;
          if (req_err || (req_we && !req_split)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_err;
            rsp_rdata <= 32'h0;
          end else if (req_we) begin
            state_reg <= WR2;
          end else begin
            state_reg <= RD1;
          end
        end
        RD1: if (split_reg) begin
          lo_reg    <= ram_q;
          state_reg <= RD2;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lane_rdata;
          state_reg <= IDLE;
        end
        RD2: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lane_rdata;
          state_reg <= IDLE;
        end
        WR2: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
